// File: rtl/rot_seq_pkg.sv
// Shared widths, FSM state encoding and amount arithmetic for the rotate sequencer.
package rot_seq_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  typedef enum logic [1:0] {IDLE, HOLD, RUN} state_t;

  // Negating the amount while flipping direction leaves the rotated pattern where it was.
  function automatic logic [AMT_W-1:0] amt_neg(input logic [AMT_W-1:0] v);
    return -v;
  endfunction

endpackage

// File: rtl/rot_seq_ctrl_if.sv
// Control inputs and shifter-facing outputs of the rotate sequencer.
interface rot_seq_ctrl_if;
  import rot_seq_pkg::*;

  logic              load;
  logic [DATA_W-1:0] din;
  logic              dir;
  logic              run;
  logic              step;
  logic [DATA_W-1:0] a;
  logic [AMT_W-1:0]  amt;
  logic              lr;
  logic              adv;
  logic              running;

  modport master (output load, din, dir, run, step,
                  input  a, amt, lr, adv, running);
  modport slave  (input  load, din, dir, run, step,
                  output a, amt, lr, adv, running);
endinterface

// File: rtl/rot_seq_ctrl_tick_gen.sv
// Modulo-TICK_DIV prescaler; tick is high while the count sits at TICK_DIV-1.
module tick_gen #(
  parameter int TICK_DIV = 10_000_000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rot_seq_ctrl.sv
// Rotate-shifter sequencer: IDLE/HOLD/RUN FSM driving pattern, amount and direction.
// Build option ROT_SEQ_BOUNCE_EN: ping-pong direction after 7 auto-advances in RUN.
module rot_seq_ctrl
  import rot_seq_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input logic          clk,
  input logic          reset,
  rot_seq_ctrl_if.slave bus
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] a, a_nxt;
  logic [AMT_W-1:0]  amt, amt_nxt, amt_base;
  logic              lr, lr_nxt;
  logic              adv, adv_nxt;
  logic              running, running_nxt;
  logic              advance, flip;
  logic              tick, presc_clr, presc_en;
`ifdef ROT_SEQ_BOUNCE_EN
  logic [2:0]        bcnt, bcnt_nxt;
`endif

  assign presc_en = (state == RUN);

  tick_gen #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (presc_clr),
    .en    (presc_en),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    amt_nxt   = amt;
    lr_nxt    = lr;
    adv_nxt   = 1'b0;
    presc_clr = 1'b0;
    advance   = 1'b0;
    flip      = 1'b0;
    amt_base  = amt;
`ifdef ROT_SEQ_BOUNCE_EN
    bcnt_nxt  = bcnt;
`endif
    if (bus.load) begin
      state_nxt = HOLD;
      a_nxt     = bus.din;
      amt_nxt   = '0;
      lr_nxt    = bus.dir;
      presc_clr = 1'b1;
`ifdef ROT_SEQ_BOUNCE_EN
      bcnt_nxt  = '0;
`endif
    end else begin
      case (state)
        IDLE: ;
        HOLD: begin
          if (bus.run) begin
            state_nxt = RUN;
            presc_clr = 1'b1;
`ifdef ROT_SEQ_BOUNCE_EN
            bcnt_nxt  = '0;
`endif
          end
          advance = bus.step;
          flip    = (bus.dir != lr);
        end
        RUN: begin
          if (!bus.run) state_nxt = HOLD;
          else          advance   = tick;
`ifdef ROT_SEQ_BOUNCE_EN
          // The bounce fires the cycle after the 7th advance, never on a tick edge.
          flip = bus.run && (bcnt == 3'd7);
          if (flip)         bcnt_nxt = '0;
          else if (advance) bcnt_nxt = bcnt + 3'd1;
`else
          flip = (bus.dir != lr);
`endif
        end
        default: state_nxt = IDLE;
      endcase
      amt_base = flip ? amt_neg(amt) : amt;
      amt_nxt  = amt_base + AMT_W'(advance);
      lr_nxt   = flip ? ~lr : lr;
      adv_nxt  = advance;
    end
    running_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a       <= '0;
      amt     <= '0;
      lr      <= 1'b0;
      adv     <= 1'b0;
      running <= 1'b0;
`ifdef ROT_SEQ_BOUNCE_EN
      bcnt    <= '0;
`endif
    end else begin
      state   <= state_nxt;
      a       <= a_nxt;
      amt     <= amt_nxt;
      lr      <= lr_nxt;
      adv     <= adv_nxt;
      running <= running_nxt;
`ifdef ROT_SEQ_BOUNCE_EN
      bcnt    <= bcnt_nxt;
`endif
    end
  end

  assign bus.a       = a;
  assign bus.amt     = amt;
  assign bus.lr      = lr;
  assign bus.adv     = adv;
  assign bus.running = running;

endmodule

// File: tb/tb_rot_seq_ctrl.sv
// Scoreboard bench for rot_seq_ctrl (TICK_DIV=4); ROT_SEQ_BOUNCE_EN selects the bounce scenario.
module tb_rot_seq_ctrl;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [2:0] amt;
    logic       lr;
    logic       adv;
    logic       running;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cycle  = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t probe_q[$];
  exp_t adv_q[$];
  exp_t e;

  rot_seq_ctrl_if bus();

  rot_seq_ctrl #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic pexp(input int c, input logic [7:0] a, input logic [2:0] amt,
                      input logic lr, input logic adv, input logic running);
    exp_t x;
    x.cyc = c; x.a = a; x.amt = amt; x.lr = lr; x.adv = adv; x.running = running;
    probe_q.push_back(x);
  endtask

  task automatic aexp(input int c, input logic [7:0] a, input logic [2:0] amt,
                      input logic lr, input logic running);
    exp_t x;
    x.cyc = c; x.a = a; x.amt = amt; x.lr = lr; x.adv = 1'b1; x.running = running;
    adv_q.push_back(x);
  endtask

  // Monitor: every adv pulse consumes one advance expectation; probes are due at a given cycle.
  always @(negedge clk) begin
    if (bus.adv === 1'b1) begin
      checks++;
      if (adv_q.size() == 0) begin
        errors++;
        $display("FAIL adv_unexpected cyc=%0d got amt=%0d lr=%b, required no pulse", cycle, bus.amt, bus.lr);
      end else begin
        e = adv_q.pop_front();
        if (e.cyc != cycle || bus.a !== e.a || bus.amt !== e.amt || bus.lr !== e.lr || bus.running !== e.running) begin
          errors++;
          $display("FAIL adv cyc=%0d got a=%h amt=%0d lr=%b running=%b, required cyc=%0d a=%h amt=%0d lr=%b running=%b",
                   cycle, bus.a, bus.amt, bus.lr, bus.running, e.cyc, e.a, e.amt, e.lr, e.running);
        end
      end
    end
    while (probe_q.size() > 0 && probe_q[0].cyc <= cycle) begin
      e = probe_q.pop_front();
      checks++;
      if (e.cyc != cycle || bus.a !== e.a || bus.amt !== e.amt || bus.lr !== e.lr ||
          bus.adv !== e.adv || bus.running !== e.running) begin
        errors++;
        $display("FAIL probe cyc=%0d got a=%h amt=%0d lr=%b adv=%b running=%b, required cyc=%0d a=%h amt=%0d lr=%b adv=%b running=%b",
                 cycle, bus.a, bus.amt, bus.lr, bus.adv, bus.running, e.cyc, e.a, e.amt, e.lr, e.adv, e.running);
      end
    end
  end

  initial begin
    int c;
    reset = 1'b1;
    bus.load = 1'b0; bus.din = 8'h00; bus.dir = 1'b0; bus.run = 1'b0; bus.step = 1'b0;

    // Reset for two cycles, then IDLE must ignore run and step.
    clk1();
    pexp(cycle, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    clk1();
    reset = 1'b0; bus.run = 1'b1; bus.step = 1'b1;
    pexp(cycle + 1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    clk1();
    bus.step = 1'b0; clk1();
    bus.step = 1'b1; clk1();
    bus.step = 1'b0;
    pexp(cycle + 1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    clk1();

    // Load, then eight manual steps with wrap 7 -> 0.
    bus.run = 1'b0; bus.load = 1'b1; bus.din = 8'h81; bus.dir = 1'b0;
    pexp(cycle + 1, 8'h81, 3'd0, 1'b0, 1'b0, 1'b0);
    clk1();
    bus.load = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus.step = 1'b1;
      aexp(cycle + 1, 8'h81, 3'(i % 8), 1'b0, 1'b0);
      clk1();
      bus.step = 1'b0;
      clk1();
    end

    // RUN: first advance 4 cycles after entry, then every 4; drop run at amt=5.
    c = cycle;
    bus.run = 1'b1;
    pexp(c + 1, 8'h81, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) aexp(c + 1 + 4 * k, 8'h81, 3'(k), 1'b0, 1'b1);
    while (cycle < c + 21) clk1();
    bus.run = 1'b0;
    pexp(c + 22, 8'h81, 3'd5, 1'b0, 1'b0, 1'b0);
    clk1();
    pexp(cycle + 1, 8'h81, 3'd5, 1'b0, 1'b0, 1'b0);
    clk1();

`ifdef ROT_SEQ_BOUNCE_EN
    // Ping-pong: 7 left advances, continuous flip, 7 right advances; dir ignored in RUN.
    bus.load = 1'b1; bus.din = 8'h01; bus.dir = 1'b0; bus.run = 1'b1;
    pexp(cycle + 1, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0);
    clk1();
    bus.load = 1'b0;
    c = cycle + 1;
    pexp(c, 8'h01, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) aexp(c + 4 * k, 8'h01, 3'(k), 1'b0, 1'b1);
    pexp(c + 29, 8'h01, 3'd1, 1'b1, 1'b0, 1'b1);
    for (int j = 1; j <= 7; j++) aexp(c + 28 + 4 * j, 8'h01, 3'((1 + j) % 8), 1'b1, 1'b1);
    pexp(c + 57, 8'h01, 3'd0, 1'b0, 1'b0, 1'b1);
    while (cycle < c + 10) clk1();
    bus.dir = 1'b1;
    while (cycle < c + 57) clk1();
    bus.dir = 1'b0; bus.run = 1'b0;
    pexp(cycle + 1, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0);
    clk1();
`else
    // Direction flip in HOLD: amt 5 -> 3, lr 0 -> 1.
    bus.dir = 1'b1;
    pexp(cycle + 1, 8'h81, 3'd3, 1'b1, 1'b0, 1'b0);
    clk1();

    // Flip coincident with a RUN tick: amt 4 -> (8-4)+1 = 5.
    c = cycle;
    bus.run = 1'b1;
    pexp(c + 1, 8'h81, 3'd3, 1'b1, 1'b0, 1'b1);
    aexp(c + 5, 8'h81, 3'd4, 1'b1, 1'b1);
    while (cycle < c + 8) clk1();
    bus.dir = 1'b0;
    aexp(c + 9, 8'h81, 3'd5, 1'b0, 1'b1);
    clk1();

    // Load during RUN wins: HOLD for one cycle, then RUN again since run stays high.
    bus.load = 1'b1; bus.din = 8'h0F; bus.dir = 1'b1;
    pexp(cycle + 1, 8'h0F, 3'd0, 1'b1, 1'b0, 1'b0);
    clk1();
    bus.load = 1'b0;
    pexp(cycle + 1, 8'h0F, 3'd0, 1'b1, 1'b0, 1'b1);
    clk1();
`endif

    // Reset asserted mid-RUN.
    bus.run = 1'b1;
    clk1();
    clk1();
    clk1();
    reset = 1'b1;
    pexp(cycle + 1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    clk1();
    reset = 1'b0;
    pexp(cycle + 1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (6) clk1();
    @(negedge clk);
    #1;

    checks++;
    if (adv_q.size() != 0) begin
      errors++;
      $display("FAIL adv_pending got %0d outstanding advances, required 0", adv_q.size());
    end
    checks++;
    if (probe_q.size() != 0) begin
      errors++;
      $display("FAIL probe_pending got %0d outstanding probes, required 0", probe_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rot_seq_ctrl.md
Name: rot_seq_ctrl

Overview:
- Sequencing stage that sits directly upstream of the 8-bit rotate barrel shifter and drives its pattern, shift-amount and direction inputs.
- Holds a loaded 8-bit pattern and advances the rotation amount either one step per prescaled tick (run mode) or one step per button pulse (step mode).
- On a direction change it keeps the shifter output visually continuous: the pattern on the LEDs does not jump.

Parameters:
- TICK_DIV, 10_000_000, clk cycles per automatic step in RUN; legal range >= 2.
- CNT_W, $clog2(TICK_DIV), width of the prescaler counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle pulse: capture din, restart the sequence.
- din  in  8  pattern to load.
- dir  in  1  requested direction: 1 = right, 0 = left (same encoding as the shifter's lr).
- run  in  1  level: 1 = auto-advance, 0 = hold.
- step  in  1  one-cycle pulse: single advance while holding.
- a  out  8  pattern to the shifter.
- amt  out  3  rotation amount to the shifter.
- lr  out  1  direction to the shifter.
- adv  out  1  one-cycle pulse, asserted in the same cycle amt changes because of an advance.
- running  out  1  1 while the FSM is in RUN.

Behaviour:
- All outputs are registered. Reset gives a=0, amt=0, lr=0, adv=0, running=0, FSM=IDLE, prescaler=0.
- FSM states are IDLE, HOLD and RUN.
  - IDLE: run, step and dir are ignored. load goes to HOLD.
  - HOLD: run=1 goes to RUN and clears the prescaler. step=1 advances on that edge: amt+1 mod 8, adv=1.
  - RUN: run=0 goes to HOLD and keeps amt. step is ignored. The prescaler counts 0..TICK_DIV-1; on the TICK_DIV-1 cycle it wraps to 0 and the block advances.
- First auto step occurs exactly TICK_DIV cycles after entering RUN.
- load has highest priority in every state. On load: a<=din, amt<=0, lr<=dir, prescaler<=0, adv=0, FSM<=HOLD. run is not sampled that cycle.
- Direction change applies only in HOLD and RUN, when dir != lr and load=0:
  - lr<=dir and amt<=(8-amt) mod 8, i.e. 3-bit two's-complement negate, so the shifter output is unchanged.
  - If an advance happens in the same cycle: amt<=((8-amt)+1) mod 8 and adv=1.
- Wrap: amt 7 advances to 0. amt arithmetic is 3-bit modulo throughout.
- Synchronous reset asserted mid-sequence forces the reset values at the next edge, whatever the other inputs are.
- Latency: an input sampled at edge N is visible on the outputs after edge N. Shifter y reflects it combinationally.

Optional Feature:
- Macro: ROT_SEQ_BOUNCE_EN.
- Defined:
  - In RUN, dir is ignored.
  - An internal 3-bit step counter (cleared on load and on entering RUN) counts auto-advances.
  - After the 7th auto-advance in one direction, the next cycle toggles lr using the negate rule above and clears the counter. The pattern ping-pongs.
  - Manual steps in HOLD do not count. dir is honoured in HOLD.
- Not defined: no step counter, and dir is honoured in all states except IDLE.

Decomposition:
- Package rot_seq_pkg holds DATA_W=8, AMT_W=3 and the enum state_t {IDLE, HOLD, RUN}.
- One sub-module, tick_gen:
  - Parameterised mod-TICK_DIV counter with ports clk, reset, clr, en, tick.
  - tick is high on the TICK_DIV-1 count.
- All other logic stays in rot_seq_ctrl.

Test Plan (TICK_DIV=4):
- Reset held 2 cycles, then run=1 and step pulses -> a=0x00, amt=0, lr=0, running=0, adv never asserted (FSM stays IDLE).
- load din=0x81, dir=0 -> next edge a=0x81, amt=0, lr=0. Then step ×3 -> amt 1,2,3, one adv per step. Then step ×5 more -> amt wraps 7→0.
- HOLD with amt=0, run=1 -> adv pulses every 4 cycles, amt 1,2,…; first pulse 4 cycles after entry. Drop run at amt=5 -> running=0, amt stays 5.
- amt=3, lr=0, toggle dir to 1 -> next edge lr=1, amt=5, shifter y unchanged. Same toggle coincident with a RUN tick -> amt=6, adv=1.
- In RUN at amt=6, assert load din=0x0F with dir=1 -> a=0x0F, amt=0, lr=1, FSM=HOLD, no adv. Reset pulsed mid-RUN -> all outputs return to reset values.
- With ROT_SEQ_BOUNCE_EN, load 0x01, dir=0, run=1 -> 7 left advances, then lr flips to 1 with y continuous, then 7 right advances; dir toggling during RUN has no effect.
